// File: rtl/pencere_uretici.sv
// 3x3 sliding-window generator: buffers two image rows and serialises each window's 9 taps to medyan_birimi.
// Optional build macro PENCERE_KENAR_EN: emit a zero-padded window for every pixel, edges included.
module pencere_uretici #(
  parameter int GENISLIK  = 320,
  parameter int YUKSEKLIK = 240,
  parameter int PIXEL_BIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 yeni_kare_i,
  input  logic [PIXEL_BIT-1:0] piksel_i,
  input  logic                 piksel_gecerli_i,
  output logic                 piksel_hazir_o,
  output logic [PIXEL_BIT-1:0] sayi_o,
  output logic                 etkin_o,
  input  logic                 medyan_hazir_i,
  output logic                 kare_sonu_o
);

  localparam int SW  = $clog2(GENISLIK);
  localparam int SAW = $clog2(YUKSEKLIK);

  typedef enum logic [1:0] {KABUL, GONDER, BEKLE} durum_e;

  durum_e               durum_q;
  logic [SW-1:0]        sutun_q;
  logic [SAW-1:0]       satir_q;
  logic [3:0]           tap_q;
  logic                 hazir_q;
  logic                 etkin_q;
  logic                 kare_sonu_q;
  logic [PIXEL_BIT-1:0] pencere_q [3][3];

  // Row r-1 and row r-2 line buffers.
  logic [PIXEL_BIT-1:0] satir1_mem [GENISLIK];
  logic [PIXEL_BIT-1:0] satir2_mem [GENISLIK];
  logic [PIXEL_BIT-1:0] satir1_rd;
  logic [PIXEL_BIT-1:0] satir2_rd;

  logic                 kabul;
  logic                 son_sutun;
  logic                 son_satir;
  logic                 pencere_gecerli;
  logic [2:0]           satir_ok;
  logic [2:0]           sutun_ok;
  logic [PIXEL_BIT-1:0] tap_deger;

  assign kabul     = piksel_gecerli_i && hazir_q && !yeni_kare_i;
  assign son_sutun = (sutun_q == SW'(GENISLIK - 1));
  assign son_satir = (satir_q == SAW'(YUKSEKLIK - 1));
  assign satir1_rd = satir1_mem[sutun_q];
  assign satir2_rd = satir2_mem[sutun_q];

`ifdef PENCERE_KENAR_EN
  // Padding masks captured from the counters of the accepted pixel; bit k covers window row/column k.
  logic [1:0] satir_ok_q;
  logic [1:0] sutun_ok_q;

  assign pencere_gecerli = 1'b1;
  assign satir_ok        = {1'b1, satir_ok_q};
  assign sutun_ok        = {1'b1, sutun_ok_q};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      satir_ok_q <= '0;
      sutun_ok_q <= '0;
    end else if (kabul) begin
      satir_ok_q <= {satir_q >= SAW'(1), satir_q >= SAW'(2)};
      sutun_ok_q <= {sutun_q >= SW'(1), sutun_q >= SW'(2)};
    end
  end
`else
  assign pencere_gecerli = (satir_q >= SAW'(2)) && (sutun_q >= SW'(2));
  assign satir_ok        = 3'b111;
  assign sutun_ok        = 3'b111;
`endif

  // NOTE: default assignment first so the tap mux cannot infer a latch.
  always_comb begin
    tap_deger = '0;
    for (int i = 0; i < 9; i++) begin
      if (tap_q == 4'(i) && satir_ok[i/3] && sutun_ok[i%3]) begin
        tap_deger = pencere_q[i/3][i%3];
      end
    end
  end

  // NOTE: line buffers carry no reset; stale rows are never emitted unmasked.
  always_ff @(posedge clk_i) begin
    if (kabul) begin
      satir2_mem[sutun_q] <= satir1_rd;
      satir1_mem[sutun_q] <= piksel_i;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q     <= KABUL;
      sutun_q     <= '0;
      satir_q     <= '0;
      tap_q       <= '0;
      hazir_q     <= 1'b1;
      etkin_q     <= 1'b0;
      kare_sonu_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) pencere_q[r][c] <= '0;
      end
    end else if (yeni_kare_i) begin
      durum_q     <= KABUL;
      sutun_q     <= '0;
      satir_q     <= '0;
      tap_q       <= '0;
      hazir_q     <= 1'b1;
      etkin_q     <= 1'b0;
      kare_sonu_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) pencere_q[r][c] <= '0;
      end
    end else begin
      kare_sonu_q <= 1'b0;
      case (durum_q)
        KABUL: begin
          if (kabul) begin
            sutun_q <= son_sutun ? '0 : sutun_q + 1'b1;
            if (son_sutun) satir_q <= son_satir ? '0 : satir_q + 1'b1;
            kare_sonu_q <= son_sutun && son_satir;
            for (int r = 0; r < 3; r++) begin
              pencere_q[r][0] <= pencere_q[r][1];
              pencere_q[r][1] <= pencere_q[r][2];
            end
            pencere_q[0][2] <= satir2_rd;
            pencere_q[1][2] <= satir1_rd;
            pencere_q[2][2] <= piksel_i;
            if (pencere_gecerli) begin
              durum_q <= GONDER;
              hazir_q <= 1'b0;
              etkin_q <= 1'b1;
              tap_q   <= '0;
            end
          end
        end
        GONDER: begin
          if (tap_q == 4'd8) begin
            durum_q <= BEKLE;
            etkin_q <= 1'b0;
            tap_q   <= '0;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        BEKLE: begin
          if (medyan_hazir_i) begin
            durum_q <= KABUL;
            hazir_q <= 1'b1;
          end
        end
        default: begin
          durum_q <= KABUL;
          hazir_q <= 1'b1;
          etkin_q <= 1'b0;
        end
      endcase
    end
  end

  assign piksel_hazir_o = hazir_q;
  assign etkin_o        = etkin_q;
  assign sayi_o         = etkin_q ? tap_deger : '0;
  assign kare_sonu_o    = kare_sonu_q;

endmodule

// File: tb/tb_pencere_uretici.sv
// Directed bench for pencere_uretici on a 4x3 image of pixels 1..12 with a delayed medyan_hazir responder.
// Works for both builds; PENCERE_KENAR_EN switches the expected window set.
module tb_pencere_uretici;

  localparam int W = 4;
  localparam int H = 3;
  localparam int PB = 8;
  localparam int LONG_WAIT = 13;

`ifdef PENCERE_KENAR_EN
  localparam int FIRST_WIN = 1;
  localparam int HAND_A_IDX = 0;
  localparam int HAND_B_IDX = 5;
  localparam int HAND_A [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  localparam int HAND_B [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
`else
  localparam int FIRST_WIN = 11;
  localparam int HAND_A_IDX = 0;
  localparam int HAND_B_IDX = 1;
  localparam int HAND_A [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  localparam int HAND_B [9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          yeni_kare_i;
  logic [PB-1:0] piksel_i;
  logic          piksel_gecerli_i;
  logic          piksel_hazir_o;
  logic [PB-1:0] sayi_o;
  logic          etkin_o;
  logic          medyan_hazir_i;
  logic          kare_sonu_o;

  int            checks = 0;
  int            failures = 0;
  logic [PB-1:0] taps [$];
  int            exp_taps [$];
  int            kare_cnt = 0;
  int            resp_cnt = 0;
  logic          etkin_prev = 1'b0;

  pencere_uretici #(.GENISLIK(W), .YUKSEKLIK(H), .PIXEL_BIT(PB)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .yeni_kare_i      (yeni_kare_i),
    .piksel_i         (piksel_i),
    .piksel_gecerli_i (piksel_gecerli_i),
    .piksel_hazir_o   (piksel_hazir_o),
    .sayi_o           (sayi_o),
    .etkin_o          (etkin_o),
    .medyan_hazir_i   (medyan_hazir_i),
    .kare_sonu_o      (kare_sonu_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Window emitted for raster index p (0..11)?
  function automatic bit windowed(input int p);
`ifdef PENCERE_KENAR_EN
    return 1'b1;
`else
    return (p / W >= 2) && (p % W >= 2);
`endif
  endfunction

  // Reference: tap (i,j) of pixel (r,c) is image pixel (r-2+i, c-2+j), zero outside the image.
  function automatic void build_expected();
    exp_taps.delete();
    for (int p = 0; p < W * H; p++) begin
      if (windowed(p)) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            int rr = p / W - 2 + i;
            int cc = p % W - 2 + j;
            exp_taps.push_back((rr < 0 || cc < 0) ? 0 : rr * W + cc + 1);
          end
        end
      end
    end
  endfunction

  // Monitor plus medyan_hazir responder: pulse arrives 3 cycles after etkin_o falls.
  initial begin
    medyan_hazir_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (medyan_hazir_i) medyan_hazir_i = 1'b0;
      if (kare_sonu_o) kare_cnt++;
      if (etkin_o) taps.push_back(sayi_o);
      if (etkin_prev && !etkin_o) begin
        resp_cnt = 3;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) medyan_hazir_i = 1'b1;
      end
      etkin_prev = etkin_o;
    end
  end

  // Called and returns at a negedge; counts negedges spent waiting for ready.
  task automatic send_pixel(input int v, output int waits);
    piksel_i         = PB'(v);
    piksel_gecerli_i = 1'b1;
    waits            = 0;
    while (!piksel_hazir_o && waits < 200) begin
      @(negedge clk_i);
      waits++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_frame(input string tag);
    int w;
    for (int k = 0; k < W * H; k++) begin
      send_pixel(k + 1, w);
      check($sformatf("%s_wait_px%0d", tag, k + 1), w,
            (k > 0 && windowed(k - 1)) ? LONG_WAIT : 0);
    end
    piksel_gecerli_i = 1'b0;
    repeat (25) @(negedge clk_i);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_ntap"}, taps.size(), exp_taps.size());
    for (int i = 0; i < exp_taps.size(); i++) begin
      check($sformatf("%s_tap%0d", tag, i),
            (i < taps.size()) ? 32'(taps[i]) : 32'hFFFF_FFFF, exp_taps[i]);
    end
    check({tag, "_kare_sonu"}, kare_cnt, 1);
  endtask

  task automatic check_window(input string tag, input int widx, input int tbl [9]);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_t%0d", tag, k),
            (widx * 9 + k < taps.size()) ? 32'(taps[widx * 9 + k]) : 32'hFFFF_FFFF, tbl[k]);
    end
  endtask

  task automatic start_frame();
    taps.delete();
    kare_cnt = 0;
  endtask

  initial begin
    int w;
    int guard;
    build_expected();
    rstn_i           = 1'b0;
    yeni_kare_i      = 1'b0;
    piksel_i         = '0;
    piksel_gecerli_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_hazir", piksel_hazir_o, 1);
    check("rst_etkin", etkin_o, 0);
    check("rst_sayi", sayi_o, 0);
    check("rst_kare_sonu", kare_sonu_o, 0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Basic windows and back-pressure with valid held high.
    start_frame();
    send_frame("basic");
    compare_frame("basic");
    check_window("basic_winA", HAND_A_IDX, HAND_A);
    check_window("basic_winB", HAND_B_IDX, HAND_B);

    // Frame restart during tap 4 of the first window.
    for (int p = 1; p <= FIRST_WIN; p++) send_pixel(p, w);
    piksel_gecerli_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("restart_tap4_etkin", etkin_o, 1);
    check("restart_tap4_sayi", sayi_o, HAND_A[4]);
    yeni_kare_i = 1'b1;
    @(negedge clk_i);
    yeni_kare_i = 1'b0;
    check("restart_abort_etkin", etkin_o, 0);
    check("restart_abort_sayi", sayi_o, 0);
    check("restart_abort_hazir", piksel_hazir_o, 1);
    repeat (10) @(negedge clk_i);
    // A pixel presented together with yeni_kare must be dropped.
    piksel_i         = 8'd99;
    piksel_gecerli_i = 1'b1;
    yeni_kare_i      = 1'b1;
    @(negedge clk_i);
    yeni_kare_i = 1'b0;
    start_frame();
    send_frame("restart");
    compare_frame("restart");

    // Asynchronous reset while waiting for the median unit.
    for (int p = 1; p <= FIRST_WIN; p++) send_pixel(p, w);
    piksel_gecerli_i = 1'b0;
    guard = 0;
    while (etkin_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check("areset_in_bekle_hazir", piksel_hazir_o, 0);
    check("areset_in_bekle_etkin", etkin_o, 0);
    #2 rstn_i = 1'b0;
    #1;
    check("areset_hazir", piksel_hazir_o, 1);
    check("areset_etkin", etkin_o, 0);
    check("areset_sayi", sayi_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);
    start_frame();
    send_frame("after_reset");
    compare_frame("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pencere_uretici.md
# pencere_uretici

3x3 sliding-window generator that sits directly upstream of `medyan_birimi`. It accepts a raster-order pixel stream and keeps the two previous image rows in internal line buffers. For every pixel that completes a 3x3 window, it serialises the 9 window taps into `medyan_birimi` (drives its `etkin_i`/`sayi_i`). It then holds off further input until the median unit reports `hazir_o`.

## Interface

- `GENISLIK`, default 320: image width in pixels, must be ≥3.
- `YUKSEKLIK`, default 240: image height in rows, must be ≥3.
- `clk_i`, input, 1: clock; all logic on rising edge.
- `rstn_i`, input, 1: reset; asynchronous, active-low.
- `yeni_kare_i`, input, 1: one-cycle pulse; clears row/column counters and returns FSM to KABUL; has priority over every other input.
- `piksel_i`, input, `PIXEL_BIT`: incoming pixel.
- `piksel_gecerli_i`, input, 1: `piksel_i` valid.
- `piksel_hazir_o`, output, 1: block can accept a pixel; transfer happens when valid and ready are both high.
- `sayi_o`, output, `PIXEL_BIT`: window tap to `medyan_birimi.sayi_i`.
- `etkin_o`, output, 1: tap valid, to `medyan_birimi.etkin_i`.
- `medyan_hazir_i`, input, 1: from `medyan_birimi.hazir_o`.
- `kare_sonu_o`, output, 1: one-cycle pulse on acceptance of the last pixel of a frame.

## Operation

- Counters:
  - `sutun` counts 0..GENISLIK-1 and `satir` counts 0..YUKSEKLIK-1.
  - On each accepted pixel, `sutun` increments.
  - When `sutun` wraps to 0, `satir` increments.
  - At (YUKSEKLIK-1, GENISLIK-1) both wrap to 0 and `kare_sonu_o` pulses.
- Line buffers: two RAMs of depth GENISLIK, holding row r-1 and row r-2.
  - On acceptance at column c, read both RAMs at address c.
  - Write row r-1's value into the r-2 RAM, and `piksel_i` into the r-1 RAM.
  - RAM contents are not reset.
- Window: a 3x3 register array, shifted left one column per accepted pixel.
  - New right column, top to bottom: r-2 RAM data, r-1 RAM data, `piksel_i`.
  - The window's bottom-right tap is the current pixel (row r, col c).
- Window valid: `satir`≥2 and `sutun`≥2, evaluated on the pixel just accepted.
- FSM states:
  - KABUL: `piksel_hazir_o`=1. On transfer, go to GONDER if the window is valid, otherwise stay in KABUL.
  - GONDER: `piksel_hazir_o`=0, `etkin_o`=1 for exactly 9 consecutive cycles. A 4-bit tap counter runs 0..8. Tap order is row-major: (r-2,c-2), (r-2,c-1), (r-2,c), (r-1,c-2) … (r,c). After tap 8, go to BEKLE.
  - BEKLE: `piksel_hazir_o`=0, `etkin_o`=0. When `medyan_hazir_i`=1, go to KABUL.
- `medyan_hazir_i` is ignored in KABUL and GONDER.
- `sayi_o` = 0 whenever `etkin_o`=0.
- `yeni_kare_i`:
  - Clears the counters, tap counter and window registers, and forces KABUL.
  - An in-flight GONDER is aborted, with `etkin_o` low the next cycle.
  - A pixel presented in the same cycle is not accepted.
- Width: taps pass through unmodified; no arithmetic on pixel data.

## Timing

- Reset values: `piksel_hazir_o`=1 (state KABUL), `etkin_o`=0, `sayi_o`=0, `kare_sonu_o`=0; counters 0; window registers 0.
- Latency: accepting edge N → first tap at edge N+1 → `etkin_o` high during cycles N+1..N+9 → BEKLE from N+10.
- `medyan_hazir_i` sampled high at edge M → `piksel_hazir_o`=1 after edge M.
- Non-valid-window pixels: one pixel accepted per cycle, no bubbles.
- `kare_sonu_o` is registered and high in the cycle after the last pixel is accepted.
- If the last pixel's window is valid, GONDER still runs; the counters are already at 0,0.
- Reset asserted mid-GONDER: outputs go to reset values immediately (asynchronous).

## Configuration

- `PENCERE_KENAR_EN` not defined: windows are emitted only for `satir`≥2 and `sutun`≥2; edge pixels produce no output.
- `PENCERE_KENAR_EN` defined:
  - Every accepted pixel triggers GONDER.
  - Taps with row index <0 or column index <0 are forced to 0 (zero padding).
  - This masking is based on counters, never on RAM or window contents.

## Test plan

- Setup for all scenarios: GENISLIK=4, YUKSEKLIK=3, pixels 1..12 in raster order, `medyan_hazir_i` pulsed 3 cycles after each GONDER ends.
- Basic windows: pixel 11 → taps 1,2,3,5,6,7,9,10,11. Pixel 12 → taps 2,3,4,6,7,8,10,11,12. No `etkin_o` for pixels 1–10. `kare_sonu_o` pulses once, after pixel 12.
- Back-pressure: `piksel_gecerli_i` held high throughout → `piksel_hazir_o` low from the cycle after pixel 11 until `medyan_hazir_i` is seen. Pixel 12 is not lost.
- Frame restart: `yeni_kare_i` during tap 4 of the first window → `etkin_o` low next cycle, then a fresh frame 1..12 reproduces the basic-windows taps exactly.
- Async reset: `rstn_i` low mid-BEKLE → `piksel_hazir_o`=1, `etkin_o`=0 and `sayi_o`=0 immediately. Next frame correct.
- `PENCERE_KENAR_EN` defined:
  - Pixel 1 → taps 0,0,0,0,0,0,0,0,1.
  - Pixel 6 (row 1, col 1) → taps 0,0,0,0,1,2,0,5,6.
  - 12 windows per frame.
